matrix_op_engine: RTL and testbench
===================================

MATRIX_OP_ENGINE -- requirements
Module: matrix_op_engine

Interface
REQ-001 Parameter DIM, default 5: matrix is DIM x DIM elements.
REQ-002 Parameter ELEM_W, default 8: element width, signed two's complement.
REQ-003 Parameter WORD_W, default 256: memory word width; SHALL satisfy WORD_W >= DIM*DIM*ELEM_W.
REQ-004 Parameter ADDR_W, default 8: memory address width.
REQ-005 Parameter RD_LAT, default 1: memory read latency in cycles, range 1..4.
REQ-006 Parameter SATURATE, default 0: 0 = wrap-around arithmetic, 1 = signed saturation.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request pulse, sampled only in S_IDLE.
REQ-010 opcode  input  3  operation, encoded per REQ-019.
REQ-011 addr_a, addr_b, addr_c  input  ADDR_W each  operand A, operand B and result addresses.
REQ-012 scalar  input  ELEM_W  signed multiplier for OP_SCALE.
REQ-013 mem_addr  output  ADDR_W  single-port RAM address.
REQ-014 mem_wdata  output  WORD_W  RAM write data.
REQ-015 mem_wren  output  1  RAM write enable.
REQ-016 mem_rdata  input  WORD_W  RAM read data, valid RD_LAT cycles after mem_addr.
REQ-017 busy  output  1  high from the cycle after start is accepted until done.
REQ-018 done, error  output  1 each  single-cycle completion pulse; sticky illegal-opcode flag.

Function
REQ-019 Opcodes: 000 ADD (A+B), 001 SUB (A-B), 010 SCALE (scalar*A), 011 TRANSPOSE (A^T), 100 NEGATE (-A); 101-111 are illegal.
REQ-020 Element (r,c) SHALL occupy bits [(r*DIM+c)*ELEM_W +: ELEM_W] of a word; result bits above DIM*DIM*ELEM_W SHALL be zero.
REQ-021 FSM states: S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WR, S_DONE.
REQ-022 S_IDLE: on start=1, latch opcode, the three addresses and scalar; go to S_RD_A, or to S_DONE with error=1 if opcode is illegal.
REQ-023 S_RD_A / S_RD_B: drive addr_a / addr_b for RD_LAT+1 cycles, with mem_wren=0; capture mem_rdata in the final cycle of the state.
REQ-024 S_RD_B is skipped for SCALE, TRANSPOSE and NEGATE.
REQ-025 S_EXEC: one cycle; register the whole result word.
REQ-026 S_WR: one cycle with mem_addr=addr_c, mem_wdata=result, mem_wren=1; mem_wren SHALL be 0 in every other state.
REQ-027 S_DONE: done=1 for one cycle, then go to S_IDLE.
REQ-028 Latency: done SHALL be high in cycle 2*(RD_LAT+1)+3 after the accepting edge for two-operand ops, and (RD_LAT+1)+3 for single-operand ops; illegal opcode gives done in cycle 1.
REQ-029 start while busy SHALL be ignored; inputs other than start are don't-care outside S_IDLE.
REQ-030 Arithmetic is per element at ELEM_W bits. SCALE uses the low ELEM_W bits of a 2*ELEM_W product. With SATURATE=1, results clamp to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1], and NEGATE of the minimum value gives the maximum.
REQ-031 The error flag SHALL clear on the next accepted legal start; illegal ops perform no memory write.
REQ-032 addr_c may equal addr_a or addr_b; the operands are already captured, so in-place operation is legal.

Reset
REQ-033 Asserting reset in any state, including mid-operation, SHALL return the FSM to S_IDLE immediately.
REQ-034 Reset values: busy=0, done=0, error=0, mem_wren=0, mem_addr=0, mem_wdata=0, and operand/result registers 0.
REQ-035 A write interrupted by reset SHALL not be retried.

Structure
REQ-036 Shared package matrix_pkg SHALL hold the opcode constants, the FSM state encoding and the element-index helper.
REQ-037 The combinational datapath SHALL be the sub-module matrix_alu, with ports A, B, scalar, opcode and result, parametrised by DIM, ELEM_W, WORD_W and SATURATE; the FSM and registers stay in matrix_op_engine.

Verification
REQ-038 ADD, defaults: A all 3, B all 4 at addresses 0 and 1, addr_c=2 -> word 2 holds 25 elements of 7 and zero upper bits; done at cycle 7.
REQ-039 SUB wrap versus saturate: A=-128, B=1 -> 127 with SATURATE=0, -128 with SATURATE=1; SCALE of 100 by 2 -> -56 wrap, 127 saturate.
REQ-040 TRANSPOSE: A(r,c)=r*5+c -> result(r,c)=c*5+r; no read of addr_b occurs; done at cycle 5.
REQ-041 Illegal opcode 110 -> error=1, done in cycle 1, mem_wren never asserted; the next ADD clears error.
REQ-042 reset asserted in S_RD_B -> outputs at reset values in the same cycle, no write; a subsequent start completes normally.
REQ-043 start held high through a whole operation -> exactly one operation per S_IDLE visit; RD_LAT=3 with DIM=4 and ELEM_W=16 -> done at cycle 11 for ADD.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operation engine: opcodes, FSM encoding
// and the element bit-position helper used by the datapath.
package matrix_pkg;

    localparam logic [2:0] OP_ADD       = 3'b000;
    localparam logic [2:0] OP_SUB       = 3'b001;
    localparam logic [2:0] OP_SCALE     = 3'b010;
    localparam logic [2:0] OP_TRANSPOSE = 3'b011;
    localparam logic [2:0] OP_NEGATE    = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WR,
        S_DONE
    } state_t;

    // Element (r,c) sits at this bit offset inside a memory word.
    function automatic int elem_lsb(input int r, input int c, input int dim, input int w);
        return (r * dim + c) * w;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_NEGATE;
    endfunction

    function automatic logic op_two_operand(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_alu.sv
// Combinational per-element datapath: add, subtract, scale, transpose, negate,
// with optional signed saturation. Unused upper result bits are forced to zero.
module matrix_alu
    import matrix_pkg::*;
#(
    parameter int DIM      = 5,
    parameter int ELEM_W   = 8,
    parameter int WORD_W   = 256,
    parameter int SATURATE = 0
) (
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic [ELEM_W-1:0] scalar,
    input  logic [2:0]        opcode,
    output logic [WORD_W-1:0] result
);

    localparam int USED = DIM * DIM * ELEM_W;
    localparam logic [ELEM_W-1:0] E_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] E_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

    // A one-bit-wider sum overflowed when its top two bits disagree.
    function automatic logic [ELEM_W-1:0] fit_sum(input logic [ELEM_W:0] s);
        if (SATURATE != 0 && s[ELEM_W] != s[ELEM_W-1])
            return s[ELEM_W] ? E_MIN : E_MAX;
        return s[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] fit_prod(input logic [2*ELEM_W-1:0] p);
        if (SATURATE != 0 && p[2*ELEM_W-1:ELEM_W-1] != {(ELEM_W+1){p[2*ELEM_W-1]}})
            return p[2*ELEM_W-1] ? E_MIN : E_MAX;
        return p[ELEM_W-1:0];
    endfunction

    logic [ELEM_W-1:0]   ea, eb, et, er;
    logic [ELEM_W:0]     ext_a, ext_b;
    logic [2*ELEM_W-1:0] prod;

    always_comb begin
        result = '0;
        ea     = '0;
        eb     = '0;
        et     = '0;
        er     = '0;
        ext_a  = '0;
        ext_b  = '0;
        prod   = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                ea    = A[elem_lsb(r, c, DIM, ELEM_W) +: ELEM_W];
                eb    = B[elem_lsb(r, c, DIM, ELEM_W) +: ELEM_W];
                et    = A[elem_lsb(c, r, DIM, ELEM_W) +: ELEM_W];
                ext_a = {ea[ELEM_W-1], ea};
                ext_b = {eb[ELEM_W-1], eb};
                prod  = {{ELEM_W{ea[ELEM_W-1]}}, ea} * {{ELEM_W{scalar[ELEM_W-1]}}, scalar};
                case (opcode)
                    OP_ADD:       er = fit_sum(ext_a + ext_b);
                    OP_SUB:       er = fit_sum(ext_a - ext_b);
                    OP_SCALE:     er = fit_prod(prod);
                    OP_TRANSPOSE: er = et;
                    OP_NEGATE:    er = fit_sum({(ELEM_W+1){1'b0}} - ext_a);
                    default:      er = '0;
                endcase
                result[elem_lsb(r, c, DIM, ELEM_W) +: ELEM_W] = er;
            end
        end
    end

    generate
        if (WORD_W > USED) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^{A[WORD_W-1:USED], B[WORD_W-1:USED]};
        end
    endgenerate

endmodule

// File: rtl/matrix_op_engine.sv
// Matrix operation sequencer: reads one or two operand words from a
// single-port RAM, runs the element-wise ALU and writes the result word back.
module matrix_op_engine
    import matrix_pkg::*;
#(
    parameter int DIM      = 5,
    parameter int ELEM_W   = 8,
    parameter int WORD_W   = 256,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [ELEM_W-1:0] scalar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [ELEM_W-1:0] scalar_q, scalar_d;
    logic [WORD_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic              error_q, error_d;
    logic [WORD_W-1:0] alu_result;

    matrix_alu #(
        .DIM(DIM), .ELEM_W(ELEM_W), .WORD_W(WORD_W), .SATURATE(SATURATE)
    ) u_alu (
        .A(a_q), .B(b_q), .scalar(scalar_q), .opcode(opcode_q), .result(alu_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            scalar_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            scalar_q <= scalar_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        scalar_d = scalar_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    addr_a_d = addr_a;
                    addr_b_d = addr_b;
                    addr_c_d = addr_c;
                    scalar_d = scalar;
                    cnt_d    = '0;
                    error_d  = !op_legal(opcode);
                    state_d  = op_legal(opcode) ? S_RD_A : S_DONE;
                end
            end
            // Address is held RD_LAT+1 cycles; data is valid in the last one.
            S_RD_A: begin
                if (cnt_q == 3'(RD_LAT)) begin
                    a_d     = mem_rdata;
                    cnt_d   = '0;
                    state_d = op_two_operand(opcode_q) ? S_RD_B : S_EXEC;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RD_B: begin
                if (cnt_q == 3'(RD_LAT)) begin
                    b_d     = mem_rdata;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                state_d  = S_WR;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_RD_A:  mem_addr = addr_a_q;
            S_RD_B:  mem_addr = addr_b_q;
            S_WR:    mem_addr = addr_c_q;
            default: mem_addr = '0;
        endcase
    end

    assign mem_wdata = result_q;
    assign mem_wren  = (state_q == S_WR);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_op_engine.sv
// Bench for matrix_op_engine: a default 5x5/8-bit wrap instance and a
// 4x4/16-bit saturating instance with read latency 3, each with its own RAM.
module tb_matrix_op_engine;
    import matrix_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start [2];
    logic [2:0]   opcode [2];
    logic [7:0]   addr_a [2], addr_b [2], addr_c [2];
    logic [15:0]  scal [2];
    logic [7:0]   maddr [2];
    logic [255:0] wdata [2], rdata [2];
    logic         wren [2], busy [2], done [2], error [2];
    logic [2:0]   dbg [2];

    logic [255:0] mem [2][256];
    logic [255:0] p0;
    logic [255:0] p1 [3];
    logic         pw_en [2];
    logic [7:0]   pw_addr;
    logic [255:0] pw_data;
    int           wr_cnt [2];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    matrix_op_engine u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .opcode(opcode[0]),
        .addr_a(addr_a[0]), .addr_b(addr_b[0]), .addr_c(addr_c[0]), .scalar(scal[0][7:0]),
        .mem_addr(maddr[0]), .mem_wdata(wdata[0]), .mem_wren(wren[0]), .mem_rdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .dbg_state(dbg[0])
    );

    matrix_op_engine #(.DIM(4), .ELEM_W(16), .WORD_W(256), .ADDR_W(8), .RD_LAT(3), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .opcode(opcode[1]),
        .addr_a(addr_a[1]), .addr_b(addr_b[1]), .addr_c(addr_c[1]), .scalar(scal[1]),
        .mem_addr(maddr[1]), .mem_wdata(wdata[1]), .mem_wren(wren[1]), .mem_rdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .dbg_state(dbg[1])
    );

    // RAMs: instance 0 returns data one cycle after the address, instance 1 three.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wren[d]) begin
                mem[d][maddr[d]] <= wdata[d];
                wr_cnt[d] <= wr_cnt[d] + 1;
            end else if (pw_en[d]) begin
                mem[d][pw_addr] <= pw_data;
            end
        end
        p0    <= mem[0][maddr[0]];
        p1[0] <= mem[1][maddr[1]];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign rdata[0] = p0;
    assign rdata[1] = p1[2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dim_of(input int d);  return (d == 1) ? 4 : 5;  endfunction
    function automatic int w_of(input int d);    return (d == 1) ? 16 : 8; endfunction

    function automatic longint get_el(input logic [255:0] wd, input int idx, input int w);
        logic [255:0] sh;
        longint u;
        sh = wd >> (idx * w);
        u = longint'(sh[63:0]) & ((longint'(1) << w) - 1);
        if (u >= (longint'(1) << (w - 1))) u -= (longint'(1) << w);
        return u;
    endfunction

    function automatic logic [255:0] splat(input int d, input longint v);
        logic [255:0] res;
        longint m;
        res = '0;
        m = (longint'(1) << w_of(d)) - 1;
        for (int i = 0; i < dim_of(d) * dim_of(d); i++)
            res |= (256'(v & m)) << (i * w_of(d));
        return res;
    endfunction

    // Reference: matrices as signed integers, exact arithmetic, then clamp or wrap.
    function automatic logic [255:0] ref_op(input int d, input logic [2:0] op,
                                            input logic [255:0] wa, input logic [255:0] wb,
                                            input logic [15:0] sc);
        int dim, w;
        longint mx, mn, m, sv, a, b, v;
        logic [255:0] res;
        dim = dim_of(d);
        w   = w_of(d);
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -mx - 1;
        m   = (longint'(1) << w) - 1;
        sv  = get_el({240'b0, sc}, 0, w);
        res = '0;
        for (int r = 0; r < dim; r++) begin
            for (int c = 0; c < dim; c++) begin
                a = get_el(wa, r * dim + c, w);
                b = get_el(wb, r * dim + c, w);
                case (op)
                    3'd0:    v = a + b;
                    3'd1:    v = a - b;
                    3'd2:    v = a * sv;
                    3'd3:    v = get_el(wa, c * dim + r, w);
                    3'd4:    v = -a;
                    default: v = 0;
                endcase
                if (d == 1) begin
                    if (v > mx) v = mx;
                    if (v < mn) v = mn;
                end
                res |= (256'(v & m)) << ((r * dim + c) * w);
            end
        end
        return res;
    endfunction

    function automatic int exp_lat(input int d, input logic [2:0] op);
        int lat;
        lat = (d == 1) ? 3 : 1;
        if (op > 3'd4) return 1;
        if (op < 3'd2) return 2 * (lat + 1) + 3;
        return lat + 4;
    endfunction

    function automatic logic [255:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic poke(input int d, input logic [7:0] a, input logic [255:0] v);
        @(negedge clk);
        pw_en[d] = 1'b1;
        pw_addr  = a;
        pw_data  = v;
        @(posedge clk);
        #1 pw_en[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic [2:0] op, input logic [7:0] aa,
                          input logic [7:0] ab, input logic [7:0] ac, input logic [15:0] sc,
                          output int dcyc, output bit bread, output int wcnt);
        int w0;
        @(negedge clk);
        start[d]  = 1'b1;
        opcode[d] = op;
        addr_a[d] = aa;
        addr_b[d] = ab;
        addr_c[d] = ac;
        scal[d]   = sc;
        @(posedge clk);
        #1 start[d] = 1'b0;
        w0 = wr_cnt[d];
        dcyc = 0;
        bread = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy[d] && !wren[d] && maddr[d] == ab && ab != aa) bread = 1'b1;
            if (done[d]) begin
                dcyc = k;
                break;
            end
        end
        wcnt = wr_cnt[d] - w0;
    endtask

    task automatic do_op(input int d, input logic [2:0] op, input logic [7:0] aa,
                         input logic [7:0] ab, input logic [7:0] ac, input logic [15:0] sc,
                         input string tag, output bit br);
        logic [255:0] exp_w;
        int dc, wc;
        exp_w = ref_op(d, op, mem[d][aa], mem[d][ab], sc);
        run_op(d, op, aa, ab, ac, sc, dc, br, wc);
        check({tag, " latency"}, 256'(dc), 256'(exp_lat(d, op)));
        if (op <= 3'd4) begin
            check({tag, " word"}, mem[d][ac], exp_w);
            check({tag, " writes"}, 256'(wc), 256'd1);
        end else begin
            check({tag, " writes"}, 256'(wc), 256'd0);
        end
        check({tag, " error"}, 256'(error[d]), 256'(op > 3'd4));
    endtask

    initial begin
        logic [255:0] w;
        bit br;
        int dcount, dfirst, wbase;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; opcode[d] = '0; addr_a[d] = '0; addr_b[d] = '0;
            addr_c[d] = '0; scal[d] = '0; pw_en[d] = 1'b0; wr_cnt[d] = 0;
        end
        pw_addr = '0;
        pw_data = '0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst busy%0d", d), 256'(busy[d]), 256'd0);
            check($sformatf("rst done%0d", d), 256'(done[d]), 256'd0);
            check($sformatf("rst error%0d", d), 256'(error[d]), 256'd0);
            check($sformatf("rst wren%0d", d), 256'(wren[d]), 256'd0);
            check($sformatf("rst addr%0d", d), 256'(maddr[d]), 256'd0);
            check($sformatf("rst wdata%0d", d), wdata[d], 256'd0);
        end
        reset = 1'b0;

        // ADD of all-3 and all-4 matrices.
        poke(0, 8'd0, splat(0, 3));
        poke(0, 8'd1, splat(0, 4));
        do_op(0, OP_ADD, 8'd0, 8'd1, 8'd2, 16'd0, "add", br);
        check("add sevens", mem[0][2], splat(0, 7));
        @(negedge clk);
        check("done one pulse", 256'(done[0]), 256'd0);
        check("idle after done", 256'(busy[0]), 256'd0);

        // Wrap versus saturation corner cases.
        poke(0, 8'd3, splat(0, -128));
        poke(0, 8'd4, splat(0, 1));
        do_op(0, OP_SUB, 8'd3, 8'd4, 8'd5, 16'd0, "sub wrap", br);
        check("sub wrap elem", 256'(mem[0][5][7:0]), 256'h7f);
        poke(0, 8'd6, splat(0, 100));
        do_op(0, OP_SCALE, 8'd6, 8'd1, 8'd7, 16'd2, "scale wrap", br);
        check("scale wrap elem", 256'(mem[0][7][7:0]), 256'hc8);
        do_op(0, OP_NEGATE, 8'd3, 8'd1, 8'd8, 16'd0, "neg wrap", br);
        check("neg wrap elem", 256'(mem[0][8][7:0]), 256'h80);
        poke(1, 8'd3, splat(1, -32768));
        poke(1, 8'd4, splat(1, 1));
        do_op(1, OP_SUB, 8'd3, 8'd4, 8'd5, 16'd0, "sub sat", br);
        check("sub sat elem", 256'(mem[1][5][15:0]), 256'h8000);
        poke(1, 8'd6, splat(1, 20000));
        do_op(1, OP_SCALE, 8'd6, 8'd4, 8'd7, 16'd2, "scale sat", br);
        check("scale sat elem", 256'(mem[1][7][15:0]), 256'h7fff);
        do_op(1, OP_NEGATE, 8'd3, 8'd4, 8'd8, 16'd0, "neg sat", br);
        check("neg sat elem", 256'(mem[1][8][15:0]), 256'h7fff);
        do_op(1, OP_ADD, 8'd4, 8'd4, 8'd9, 16'd0, "add lat3", br);

        // TRANSPOSE never touches addr_b.
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r * 5 + c) * 8 +: 8] = 8'(r * 5 + c);
        poke(0, 8'd20, w);
        do_op(0, OP_TRANSPOSE, 8'd20, 8'd21, 8'd22, 16'd0, "transpose", br);
        check("transpose no b read", 256'(br), 256'd0);
        check("transpose elem r0c1", 256'(mem[0][22][15:8]), 256'd5);

        // Illegal opcode then recovery.
        poke(0, 8'd30, 256'hbeef);
        do_op(0, 3'b110, 8'd0, 8'd1, 8'd30, 16'd0, "illegal", br);
        check("illegal no write", mem[0][30], 256'hbeef);
        do_op(0, OP_ADD, 8'd0, 8'd1, 8'd31, 16'd0, "add after illegal", br);

        // Reset while reading operand B.
        poke(0, 8'd10, rand_word());
        poke(0, 8'd11, rand_word());
        poke(0, 8'd12, 256'h5e471ce1);
        wbase = wr_cnt[0];
        @(negedge clk);
        start[0] = 1'b1; opcode[0] = OP_ADD;
        addr_a[0] = 8'd10; addr_b[0] = 8'd11; addr_c[0] = 8'd12;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("in rd_b", 256'(dbg[0]), 256'(S_RD_B));
        reset = 1'b1;
        #1;
        check("mid rst state", 256'(dbg[0]), 256'(S_IDLE));
        check("mid rst busy", 256'(busy[0]), 256'd0);
        check("mid rst wren", 256'(wren[0]), 256'd0);
        check("mid rst addr", 256'(maddr[0]), 256'd0);
        check("mid rst wdata", wdata[0], 256'd0);
        check("mid rst done", 256'(done[0]), 256'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("no retried write", 256'(wr_cnt[0] - wbase), 256'd0);
        check("target intact", mem[0][12], 256'h5e471ce1);
        do_op(0, OP_ADD, 8'd10, 8'd11, 8'd12, 16'd0, "add after reset", br);

        // start held high: one operation per idle visit, period = latency + 1.
        wbase = wr_cnt[0];
        @(negedge clk);
        start[0] = 1'b1; opcode[0] = OP_ADD;
        addr_a[0] = 8'd0; addr_b[0] = 8'd1; addr_c[0] = 8'd40;
        @(posedge clk);
        dcount = 0;
        dfirst = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done[0]) begin
                dcount++;
                if (dfirst == 0) dfirst = k;
            end
            if (k == 24) start[0] = 1'b0;
        end
        check("held start done count", 256'(dcount), 256'd3);
        check("held start first done", 256'(dfirst), 256'd7);
        check("held start writes", 256'(wr_cnt[0] - wbase), 256'd3);
        @(negedge clk);
        check("held start idle", 256'(busy[0]), 256'd0);
        check("held start word", mem[0][40], splat(0, 7));

        // Random operations on both instances, including in-place results.
        for (int it = 0; it < 24; it++) begin
            int d;
            logic [7:0] aa, ab, ac;
            logic [2:0] op;
            d  = it % 2;
            op = 3'($urandom_range(0, 7));
            aa = 8'($urandom_range(100, 120));
            ab = aa + 8'($urandom_range(1, 5));
            ac = ($urandom_range(0, 2) == 0) ? aa : 8'(130 + it);
            poke(d, aa, rand_word());
            poke(d, ab, rand_word());
            do_op(d, op, aa, ab, ac, 16'($urandom), $sformatf("rand%0d op%0d d%0d", it, op, d), br);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
